// File: rtl/pipelined_add_sub_pkg.sv
// Shared constants for the pipelined adder-subtractor.
package pipelined_add_sub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int unsigned DEFAULT_WIDTH  = 16;
  localparam int unsigned DEFAULT_STAGES = 4;

endpackage : pipelined_add_sub_pkg

// File: rtl/pipelined_add_sub_slice.sv
// Combinational CHUNK-bit ripple slice: s = a + (b ^ {W{m}}) + cin.
// Also exposes the carry into its MSB so the top slice can form signed overflow.
module add_sub_slice
  import pipelined_add_sub_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         m,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [W-1:0] bx;
  logic         c;

  // Bit-serial ripple; the carry entering bit W-1 is captured on the way.
  always_comb begin
    bx    = (m == MODE_SUB) ? ~b : b;
    c     = cin;
    s     = '0;
    c_msb = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (i == W - 1) c_msb = c;
      s[i] = a[i] ^ bx[i] ^ c;
      c    = (a[i] & bx[i]) | (c & (a[i] ^ bx[i]));
    end
    cout = c;
  end

endmodule : add_sub_slice

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder-subtractor, one CHUNK-wide carry slice per stage,
// with a valid/ready stream interface and a global stall enable.
module pipelined_add_sub
  import pipelined_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned CHUNK = WIDTH / STAGES;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_cfg_check
    $error("pipelined_add_sub: WIDTH must be a non-zero multiple of STAGES");
  end

  logic en;

  // Whole pipeline advances together unless a held result blocks the output.
  always_comb begin
    en       = !out_valid || out_ready;
    in_ready = en;
  end

  // Stage k consumes operand chunk k; stage registers hold only the operand
  // chunks still to be added (right-aligned) and the result chunks produced so far.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned IW = WIDTH - k * CHUNK;
    localparam int unsigned RW = (k + 1) * CHUNK;

    logic [IW-1:0]    op_a, op_b;
    logic             op_m, cin, vin;
    logic [CHUNK-1:0] sum;
    logic             cout_w, cmsb_w;
    logic             valid_d, valid_q;
    logic             carry_d, carry_q;
    logic [RW-1:0]    res_d, res_q;

    if (k == 0) begin : g_src
      // First stage takes operands straight from the ports; mode is the carry-in.
      always_comb begin
        op_a = a;
        op_b = b;
        op_m = m;
        cin  = m;
        vin  = in_valid;
      end
    end else begin : g_src
      // Later stages take the skewed operands and carry of the previous stage.
      always_comb begin
        op_a = g_stage[k-1].g_fwd.a_q;
        op_b = g_stage[k-1].g_fwd.b_q;
        op_m = g_stage[k-1].g_fwd.m_q;
        cin  = g_stage[k-1].carry_q;
        vin  = g_stage[k-1].valid_q;
      end
    end

    add_sub_slice #(.W(CHUNK)) u_slice (
      .a     (op_a[CHUNK-1:0]),
      .b     (op_b[CHUNK-1:0]),
      .cin   (cin),
      .m     (op_m),
      .s     (sum),
      .cout  (cout_w),
      .c_msb (cmsb_w)
    );

    if (k == 0) begin : g_res
      // First result chunk starts the aligned result word.
      always_comb res_d = sum;
    end else begin : g_res
      // New chunk is appended above the delayed lower chunks.
      always_comb res_d = {sum, g_stage[k-1].res_q};
    end

    // Valid and carry simply follow the beat through the stage.
    always_comb begin
      valid_d = vin;
      carry_d = cout_w;
    end

    // Stage register: valid, carry-out and accumulated result chunks.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        res_q   <= '0;
      end else if (en) begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        res_q   <= res_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [IW-CHUNK-1:0] a_d, a_q, b_d, b_q;
      logic                m_d, m_q;

      // Drop the chunk consumed here; the rest travels with the beat.
      always_comb begin
        a_d = op_a[IW-1:CHUNK];
        b_d = op_b[IW-1:CHUNK];
        m_d = op_m;
      end

      // Operand skew register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          m_q <= 1'b0;
        end else if (en) begin
          a_q <= a_d;
          b_q <= b_d;
          m_q <= m_d;
        end
      end
    end else begin : g_last
      logic cmsb_d, cmsb_q;

      // Final slice keeps the carry into the MSB for the overflow flag.
      always_comb cmsb_d = cmsb_w;

      // Carry-into-MSB register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  cmsb_q <= 1'b0;
        else if (en) cmsb_q <= cmsb_d;
      end
    end
  end

  // Outputs and flags taken from the final stage registers.
  always_comb begin
    out_valid = g_stage[STAGES-1].valid_q;
    s         = g_stage[STAGES-1].res_q;
    cout      = g_stage[STAGES-1].carry_q;
    ovf       = g_stage[STAGES-1].g_last.cmsb_q ^ g_stage[STAGES-1].carry_q;
    zero      = (g_stage[STAGES-1].res_q == '0);
    neg       = g_stage[STAGES-1].res_q[WIDTH-1];
  end

endmodule : pipelined_add_sub

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub (16/4 main instance, 4/1 degenerate instance).
module tb_pipelined_add_sub;

  typedef struct packed {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, s;
  logic        m, cout, ovf, zero, neg;

  logic        in_valid1, in_ready1, out_valid1;
  logic [3:0]  a1, b1, s1;
  logic        m1, cout1, ovf1, zero1, neg1;

  int n_vec = 0;
  int n_err = 0;
  int rx_count = 0;

  res_t exp_q[$];
  res_t held;
  logic held_v = 1'b0;

  always #5 clk = ~clk;

  pipelined_add_sub #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .m(m), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  pipelined_add_sub #(.WIDTH(4), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .m(m1), .out_valid(out_valid1), .out_ready(1'b1),
    .s(s1), .cout(cout1), .ovf(ovf1), .zero(zero1), .neg(neg1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic res_t ref_model(input logic [15:0] x, input logic [15:0] y, input logic mm);
    res_t r;
    int unsigned ua = x;
    int unsigned ub = y;
    int sa = $signed(x);
    int sb = $signed(y);
    int sr;
    if (!mm) begin
      r.s    = 16'(ua + ub);
      r.cout = (ua + ub) > 32'd65535;
      sr     = sa + sb;
    end else begin
      r.s    = 16'(ua - ub);
      r.cout = (ua >= ub);
      sr     = sa - sb;
    end
    r.ovf = (sr > 32767) || (sr < -32768);
    return r;
  endfunction

  // Scoreboard: push on accept, pop and compare on output transfer, check stall stability.
  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      if (held_v)
        chk("stall_hold", {out_valid, s, cout, ovf}, {1'b1, held.s, held.cout, held.ovf});
      held_v = out_valid && !out_ready;
      if (held_v) held = {s, cout, ovf};
      if (out_valid && out_ready) begin
        chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("result", {s, cout, ovf, zero, neg},
              {e.s, e.cout, e.ovf, (e.s == 16'h0), e.s[15]});
          rx_count++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(a, b, m));
    end
  end

  // One isolated beat on the main instance with literal expectations and latency.
  task automatic directed(input string name, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tm, input logic [15:0] es, input logic ec,
                          input logic eo, input logic ez, input logic en_);
    int lat;
    @(posedge clk); #1;
    out_ready = 1'b1;
    a = ta; b = tb_; m = tm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'd4);
    chk({name, "_flags"}, {s, cout, ovf, zero, neg}, {es, ec, eo, ez, en_});
  endtask

  initial begin
    int sent, cyc, stale, lat, rx0;
    logic acc;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, cyc, stale, lat, rx0;
    logic acc;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; m = 1'b0;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; m1 = 1'b0;
    #2;
    chk("reset_state", {out_valid, s, cout, ovf, zero, neg, in_ready},
        {1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    chk("reset_state1", {out_valid1, s1, cout1, ovf1, zero1, neg1, in_ready1},
        {1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    chk("model_add",  ref_model(16'h1234, 16'h0FFF, 1'b0), {16'h2233, 1'b0, 1'b0});
    chk("model_sub",  ref_model(16'h0003, 16'h0005, 1'b1), {16'hFFFE, 1'b0, 1'b0});
    chk("model_ovf",  ref_model(16'h8000, 16'h0001, 1'b1), {16'h7FFF, 1'b1, 1'b1});

    directed("add",      16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0);
    directed("ripple",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    directed("borrow",   16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    directed("sub_ovf",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    directed("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);

    // Random stream with random bubbles and back-pressure.
    @(posedge clk); #1;
    rx0 = rx_count; sent = 0; cyc = 0; acc = 1'b0; in_valid = 1'b0;
    while (sent < 64 && cyc < 3000) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = 16'($urandom); b = 16'($urandom); m = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("stream_sent", 32'(sent), 32'd64);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    chk("stream_rx", 32'(rx_count - rx0), 32'd64);

    // Reset with three beats in flight, the oldest held at the output.
    @(posedge clk); #1;
    out_ready = 1'b1; m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 16'(16'h1111 * (i + 1)); b = 16'h0101; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", {out_valid, s}, {1'b1, 16'h1212});
    out_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {out_valid, s, cout, ovf, zero, in_ready},
        {1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1});
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    chk("no_stale", 32'(stale), 32'd0);
    directed("post_rst", 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

    // Degenerate single-stage, 4-bit instance.
    @(posedge clk); #1;
    a1 = 4'h9; b1 = 4'h3; m1 = 1'b1; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    lat = 1;
    while (!out_valid1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("s1_latency", 32'(lat), 32'd1);
    chk("s1_sub", {s1, cout1, ovf1, zero1, neg1}, {4'h6, 1'b1, 1'b1, 1'b0, 1'b0});
    a1 = 4'h3; b1 = 4'h9; m1 = 1'b1; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    chk("s1_borrow", {out_valid1, s1, cout1, ovf1, zero1, neg1},
        {1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 1'b1});

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pipelined_add_sub
